// File: rtl/arb8way16_pkg.sv
// Shared types and helpers for the 8-way 16-bit arbiter: state encoding and
// the requester-index to mux-select mapping.
package arb8way16_pkg;

    localparam int unsigned NumReq = 8;
    localparam int unsigned DataW  = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StFull = 1'b1
    } arb_state_e;

    // The mux select lines are a rotated form of the requester index.
    function automatic logic [2:0] k_to_lines(input logic [2:0] k);
        return {k[1:0], k[2]};
    endfunction

endpackage

// File: rtl/arb8way16_if.sv
// Requester/consumer bundle of the arbiter: eight request/data pairs on the
// producer side and one valid/ready word on the consumer side.
interface arb8way16_if;
    import arb8way16_pkg::*;

    logic [NumReq-1:0] req;
    logic [DataW-1:0]  inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8;
    logic [NumReq-1:0] ack;
    logic [DataW-1:0]  out;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        grant_id;
    logic [2:0]        lines;

    modport master (
        output req, inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8, out_ready,
        input  ack, out, out_valid, grant_id, lines
    );

    modport slave (
        input  req, inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8, out_ready,
        output ack, out, out_valid, grant_id, lines
    );

endinterface

// File: rtl/arb8way16_pick8.sv
// Combinational winner picker: round-robin scan from ptr, or lowest index
// when fixed is set.
module arb8way16_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic       fixed,
    output logic       any,
    output logic [2:0] win
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        any   = |req;
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            // 3-bit addition wraps the scan around requester 7
            idx = fixed ? 3'(i) : ptr + 3'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8way16.sv
// 16-bit 8-way multiplexer: sel 0..7 selects a..h.
module mux8way16 (
    input  logic [2:0]  sel,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        unique case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
        endcase
    end

endmodule

// File: rtl/arb8way16.sv
// Round-robin (or fixed-priority) arbiter sharing one registered 16-bit
// valid/ready output among eight requesters.
module arb8way16
    import arb8way16_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    arb8way16_if.slave   bus
);

    arb_state_e  state_q, state_d;
    logic [15:0] out_q, out_d, mux_out;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  ack_q, ack_d;
    logic [2:0]  win, sel;
    logic        any, cap;

    arb8way16_pick8 u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .fixed (FIXED_PRIO),
        .any   (any),
        .win   (win)
    );

    assign sel = reset ? 3'd0 : k_to_lines(win);

    // Inputs are permuted so that select k_to_lines(k) lands on requester k.
    mux8way16 u_mux (
        .sel (sel),
        .a   (bus.inp1),
        .b   (bus.inp5),
        .c   (bus.inp2),
        .d   (bus.inp6),
        .e   (bus.inp3),
        .f   (bus.inp7),
        .g   (bus.inp4),
        .h   (bus.inp8),
        .out (mux_out)
    );

    assign cap = any && (state_q == StIdle || bus.out_ready);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = 8'h00;
        if (cap) begin
            state_d = StFull;
            out_d   = mux_out;
            grant_d = win;
            ack_d   = 8'b1 << win;
            if (!FIXED_PRIO) rr_ptr_d = win + 3'd1;
        end else if (state_q == StFull && bus.out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            out_q    <= 16'h0000;
            grant_q  <= 3'd0;
            rr_ptr_q <= 3'd0;
            ack_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = (state_q == StFull);
    assign bus.grant_id  = grant_q;
    assign bus.ack       = ack_q;
    assign bus.lines     = sel;

endmodule
